screen_edge_detector: RTL and testbench
=======================================

# screen_edge_detector

Upstream feeder of the background state controller. Once per video frame it checks the player sprite's vertical position and velocity against the top and bottom screen edges, and emits a one-cycle `ts_collide` (top exit) or `bs_collide` (bottom exit) pulse. The controller uses these pulses to step its level tracker. For each crossing it also issues a warp request (`warp_valid`/`warp_y`/`warp_ack`) to the player motion block, then enforces a frame-based cooldown so that one crossing produces exactly one pulse.

## Interface
Parameters:
- SIZE, 16: player sprite height in pixels
- TOP_EDGE, 0: topmost visible row
- BOTTOM_EDGE, 479: bottommost visible row
- MARGIN, 8: pixel inset applied to the warp target
- COOLDOWN_FRAMES, 4: frame ticks ignored after a warp completes

Ports:
- CLK  in  1  system clock; all logic is on its rising edge
- reset  in  1  asynchronous, active-high; returns every register to its reset value immediately
- frame_clk  in  1  frame strobe (vsync domain), asynchronous to CLK
- player_y  in  10  unsigned top row of the sprite
- player_vy  in  10  signed two's-complement vertical velocity (negative = upward)
- background_number  in  11  one-hot screen code from the background controller; bits [9:0] used, bit 10 ignored
- warp_ack  in  1  player block has loaded `warp_y`
- ts_collide  out  1  one-cycle pulse: top exit
- bs_collide  out  1  one-cycle pulse: bottom exit
- warp_valid  out  1  warp request pending
- warp_y  out  10  new `player_y` for the player block
- busy  out  1  high whenever the state is not ARMED

## Operation
- frame_clk path: 3-flop chain (s1, s2, s3) on CLK; `frame_tick = s2 & ~s3`.
- Top condition:
  - `player_y <= TOP_EDGE` or `player_y >= 992` (underflow wrap), and
  - `player_vy[9] == 1`.
- Bottom condition:
  - `{1'b0,player_y} + SIZE - 1 >= BOTTOM_EDGE`, evaluated at 11 bits with no overflow, and
  - `player_vy[9] == 0` and `player_vy != 0`.
- Enables:
  - All detection is disabled when `background_number[0]` (start screen) or `background_number[9]` (end screen) is set, or when `background_number[9:0] == 0`.
  - Bottom detection is additionally disabled when `background_number[1]` is set (first level has a floor).
- FSM states: ARMED, PULSE, WARP, COOLDOWN.
  - ARMED: on `frame_tick`, an enabled top condition → PULSE with dir=TOP. Otherwise an enabled bottom condition → PULSE with dir=BOT. If both hold, TOP wins. Otherwise stay in ARMED.
  - PULSE: exactly one cycle. `ts_collide = (dir==TOP)`, `bs_collide = (dir==BOT)`. Load `warp_y`:
    - TOP: `BOTTOM_EDGE - SIZE - MARGIN + 1` (456 at defaults)
    - BOT: `TOP_EDGE + MARGIN` (8)
    - Unconditionally → WARP.
  - WARP: `warp_valid = 1`; `warp_y` stays stable. When `warp_ack` is sampled high → COOLDOWN, and the counter loads COOLDOWN_FRAMES.
  - COOLDOWN: the counter decrements on each `frame_tick`. The tick that takes it to 0 → ARMED; that tick is not evaluated for crossings. COOLDOWN_FRAMES = 0 → straight to ARMED on the next cycle.
- `warp_ack` is ignored outside WARP.
- `frame_tick` is ignored in PULSE and WARP, and is not queued.
- A change to `background_number` after ARMED has committed does not abort the sequence; PULSE, WARP and COOLDOWN always complete.
- `busy = (state != ARMED)`.

## Timing
- Reset values: state ARMED; ts_collide, bs_collide, warp_valid and busy all 0; `warp_y = 0`; counter 0; s1, s2 and s3 all 0.
- Pulse latency: let edge k be the first CLK edge that samples `frame_clk` high.
  - `frame_tick` is high in the cycle after edge k+1.
  - ts_collide or bs_collide is high for exactly the cycle following edge k+2.
- `player_y`, `player_vy` and `background_number` are sampled in the `frame_tick` cycle. They must be stable during that cycle.
- `warp_valid` rises on the edge after the pulse cycle. It falls on the edge that samples `warp_ack` high, giving a minimum high time of 1 cycle.
- Outputs are registered; there is no combinational path from input to output.
- Reset asserted mid-operation (any state): every output clears asynchronously. The first `frame_tick` after release is evaluated normally.
- Maximum rate: one pulse per (3 + ack wait + COOLDOWN_FRAMES frames).

## Test plan
- Reset: assert reset during WARP with `warp_y = 456` → warp_valid, busy and warp_y go to 0 without waiting for a CLK edge. After release, with no frame_clk, all outputs stay 0.
- Top exit, Green2:
  - Stimulus: `background_number = 0x004`, `player_y = 0`, `player_vy = 0x3FE`, one frame_clk pulse.
  - Required: ts_collide high for exactly 1 cycle on the 3rd edge, and bs_collide stays 0.
  - Next cycle: warp_valid = 1 and warp_y = 456, held through 5 cycles with warp_ack low; after the ack, warp_valid = 0.
  - With y = 0 held: ticks 1–4 give no pulse and tick 5 gives a ts pulse.
- Bottom exit:
  - `background_number = 0x008`, `player_y = 470`, `player_vy = 3` → a single bs_collide pulse, with `warp_y = 8`.
  - Same stimulus with `0x002` → no pulse, and busy stays 0.
- Disabled screens: `background_number` = 0x001, 0x200 and 0x000, each with `player_y = 0` and `player_vy = -1` over 3 frames → no pulses.
- Edge arithmetic:
  - `player_y = 1000`, `vy = -4` → ts pulse.
  - `player_y = 0`, `vy = +1` → none.
  - `player_y = 463`, `vy = 1` → none (row 478).
  - `player_y = 464`, `vy = 1` → bs pulse.
- Frame strobe and stray ack: frame_clk held high for 10 CLKs produces exactly one frame_tick. A stray warp_ack in ARMED causes no state change.

Source files
------------

// File: rtl/screen_edge_detector.sv
// Per-frame detector for the player sprite leaving the screen through the top or bottom edge.
// Ports: CLK, reset, frame_clk, player_y, player_vy, background_number, warp_ack in;
//        ts_collide, bs_collide, warp_valid, warp_y, busy out (all registered).
module screen_edge_detector #(
    parameter int SIZE            = 16,
    parameter int TOP_EDGE        = 0,
    parameter int BOTTOM_EDGE     = 479,
    parameter int MARGIN          = 8,
    parameter int COOLDOWN_FRAMES = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        frame_clk,
    input  logic [9:0]  player_y,
    input  logic [9:0]  player_vy,
    input  logic [10:0] background_number,
    input  logic        warp_ack,
    output logic        ts_collide,
    output logic        bs_collide,
    output logic        warp_valid,
    output logic [9:0]  warp_y,
    output logic        busy
);

    typedef enum logic [1:0] {ARMED, PULSE, WARP, COOLDOWN} state_t;

    localparam int CW = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

    localparam logic [9:0]    TOP_Y    = 10'(TOP_EDGE);
    localparam logic [9:0]    WRAP_Y   = 10'd992;
    localparam logic [10:0]   SIZE_M1  = 11'(SIZE - 1);
    localparam logic [10:0]   BOT_Y    = 11'(BOTTOM_EDGE);
    localparam logic [9:0]    WARP_TOP = 10'(BOTTOM_EDGE - SIZE - MARGIN + 1);
    localparam logic [9:0]    WARP_BOT = 10'(TOP_EDGE + MARGIN);
    localparam logic [CW-1:0] CD_LOAD  = CW'(COOLDOWN_FRAMES);

    state_t        state_q, state_d;
    logic          dir_top_q, dir_top_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    wy_q, wy_d;
    logic          ts_q, ts_d;
    logic          bs_q, bs_d;
    logic          wv_q, wv_d;
    logic          busy_q, busy_d;
    logic          s1_q, s2_q, s3_q;

    logic          frame_tick;
    logic [10:0]   bottom_row;
    logic          en_all, en_bot;
    logic          top_hit, bot_hit;

    // s1/s2 synchronise the vsync-domain strobe; s3 turns its rise into a single tick.
    assign frame_tick = s2_q & ~s3_q;

    // Sprite's lowest row, widened so a large player_y cannot wrap.
    assign bottom_row = {1'b0, player_y} + SIZE_M1;

    // Start screen, end screen and an empty code disable detection; level 1 has a floor.
    assign en_all = (background_number[9:0] != 10'd0) &
                    ~background_number[0] & ~background_number[9];
    assign en_bot = en_all & ~background_number[1];

    // Rows at or above 992 are a sprite that has wrapped past row 0 going up.
    assign top_hit = en_all & player_vy[9] &
                     ((player_y <= TOP_Y) | (player_y >= WRAP_Y));
    assign bot_hit = en_bot & ~player_vy[9] & (player_vy != 10'd0) &
                     (bottom_row >= BOT_Y);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= frame_clk;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_top_d = dir_top_q;
        cnt_d     = cnt_q;
        wy_d      = wy_q;
        ts_d      = 1'b0;
        bs_d      = 1'b0;
        wv_d      = 1'b0;
        unique case (state_q)
            ARMED: begin
                if (frame_tick) begin
                    if (top_hit) begin
                        state_d   = PULSE;
                        dir_top_d = 1'b1;
                        ts_d      = 1'b1;
                    end else if (bot_hit) begin
                        state_d   = PULSE;
                        dir_top_d = 1'b0;
                        bs_d      = 1'b1;
                    end
                end
            end
            PULSE: begin
                state_d = WARP;
                wy_d    = dir_top_q ? WARP_TOP : WARP_BOT;
                wv_d    = 1'b1;
            end
            WARP: begin
                if (warp_ack) begin
                    state_d = COOLDOWN;
                    cnt_d   = CD_LOAD;
                end else begin
                    wv_d = 1'b1;
                end
            end
            COOLDOWN: begin
                // The tick that empties the counter is consumed, not evaluated.
                if (cnt_q == '0) begin
                    state_d = ARMED;
                end else if (frame_tick) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = ARMED;
                    end
                end
            end
            default: state_d = ARMED;
        endcase
        busy_d = (state_d != ARMED);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= ARMED;
            dir_top_q <= 1'b0;
            cnt_q     <= '0;
            wy_q      <= 10'd0;
            ts_q      <= 1'b0;
            bs_q      <= 1'b0;
            wv_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_top_q <= dir_top_d;
            cnt_q     <= cnt_d;
            wy_q      <= wy_d;
            ts_q      <= ts_d;
            bs_q      <= bs_d;
            wv_q      <= wv_d;
            busy_q    <= busy_d;
        end
    end

    assign ts_collide = ts_q;
    assign bs_collide = bs_q;
    assign warp_valid = wv_q;
    assign warp_y     = wy_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_screen_edge_detector.sv
// Testbench for screen_edge_detector: vector table with scoreboard queue,
// plus sequences for cooldown, long strobe, stray ack and async reset.
module tb_screen_edge_detector;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [9:0]  player_y = '0;
    logic [9:0]  player_vy = '0;
    logic [10:0] background_number = '0;
    logic        warp_ack = 1'b0;
    logic        ts_collide, bs_collide, warp_valid, busy;
    logic [9:0]  warp_y;

    screen_edge_detector dut (
        .CLK(CLK), .reset(reset), .frame_clk(frame_clk),
        .player_y(player_y), .player_vy(player_vy),
        .background_number(background_number), .warp_ack(warp_ack),
        .ts_collide(ts_collide), .bs_collide(bs_collide),
        .warp_valid(warp_valid), .warp_y(warp_y), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [10:0] bn;
        logic [9:0]  y;
        logic [9:0]  vy;
        int          ts;
        int          bs;
        int          wy;
    } vec_t;

    typedef struct {
        int ts;
        int bs;
        int wy;
    } exp_t;

    localparam int NV = 16;
    vec_t vecs[NV];
    exp_t exp_q[$];

    int passed = 0;
    int total = 0;
    int n_ts, n_bs;

    task automatic check(string name, int act, int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b1;
        warp_ack = 1'b0;
        frame_clk = 1'b0;
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
    endtask

    // Count pulses over n cycles, sampling at negedge.
    task automatic watch(int n);
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            if (ts_collide) n_ts++;
            if (bs_collide) n_bs++;
        end
    endtask

    task automatic strobe(int hold);
        @(negedge CLK);
        frame_clk = 1'b1;
        for (int c = 0; c < hold; c++) begin
            @(negedge CLK);
            if (ts_collide) n_ts++;
            if (bs_collide) n_bs++;
        end
        frame_clk = 1'b0;
        watch(6);
    endtask

    task automatic run_vec(int idx);
        exp_t e;
        int first, busy_seen, wv_seen, wy_at;
        @(negedge CLK);
        background_number = vecs[idx].bn;
        player_y = vecs[idx].y;
        player_vy = vecs[idx].vy;
        frame_clk = 1'b1;
        exp_q.push_back('{vecs[idx].ts, vecs[idx].bs, vecs[idx].wy});
        n_ts = 0; n_bs = 0; first = -1;
        busy_seen = 0; wv_seen = 0; wy_at = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            if (c == 2) frame_clk = 1'b0;
            if (ts_collide) n_ts++;
            if (bs_collide) n_bs++;
            if ((ts_collide || bs_collide) && first < 0) first = c;
            if (busy) busy_seen = 1;
            if (warp_valid && wv_seen == 0) begin
                wv_seen = 1;
                wy_at = int'(warp_y);
            end
        end
        e = exp_q.pop_front();
        check($sformatf("v%0d ts_count", idx), n_ts, e.ts);
        check($sformatf("v%0d bs_count", idx), n_bs, e.bs);
        if (e.ts + e.bs > 0) begin
            check($sformatf("v%0d latency", idx), first, 3);
            check($sformatf("v%0d warp_valid", idx), wv_seen, 1);
            check($sformatf("v%0d warp_y", idx), wy_at, e.wy);
        end else begin
            check($sformatf("v%0d busy", idx), busy_seen, 0);
        end
        do_reset();
    endtask

    initial begin
        int ok;
        logic [9:0] wy_before;

        vecs[0]  = '{11'h004, 10'd0,    10'h3FE, 1, 0, 456};
        vecs[1]  = '{11'h008, 10'd470,  10'd3,   0, 1, 8};
        vecs[2]  = '{11'h002, 10'd470,  10'd3,   0, 0, 0};
        vecs[3]  = '{11'h001, 10'd0,    10'h3FF, 0, 0, 0};
        vecs[4]  = '{11'h200, 10'd0,    10'h3FF, 0, 0, 0};
        vecs[5]  = '{11'h000, 10'd0,    10'h3FF, 0, 0, 0};
        vecs[6]  = '{11'h004, 10'd1000, 10'h3FC, 1, 0, 456};
        vecs[7]  = '{11'h004, 10'd0,    10'd1,   0, 0, 0};
        vecs[8]  = '{11'h004, 10'd463,  10'd1,   0, 0, 0};
        vecs[9]  = '{11'h004, 10'd464,  10'd1,   0, 1, 8};
        vecs[10] = '{11'h002, 10'd0,    10'h3FF, 1, 0, 456};
        vecs[11] = '{11'h404, 10'd0,    10'h3FF, 1, 0, 456};
        vecs[12] = '{11'h400, 10'd0,    10'h3FF, 0, 0, 0};
        vecs[13] = '{11'h010, 10'd992,  10'h200, 1, 0, 456};
        vecs[14] = '{11'h010, 10'd991,  10'h3FF, 0, 0, 0};
        vecs[15] = '{11'h008, 10'd470,  10'd0,   0, 0, 0};

        repeat (2) @(negedge CLK);
        check("reset ts", int'(ts_collide), 0);
        check("reset bs", int'(bs_collide), 0);
        check("reset warp_valid", int'(warp_valid), 0);
        check("reset warp_y", int'(warp_y), 0);
        check("reset busy", int'(busy), 0);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Top exit, hold warp, ack, then cooldown over 4 ticks.
        background_number = 11'h004;
        player_y = 10'd0;
        player_vy = 10'h3FE;
        n_ts = 0; n_bs = 0;
        strobe(2);
        check("seq ts pulse", n_ts, 1);
        check("seq bs none", n_bs, 0);
        ok = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (!warp_valid || warp_y != 10'd456) ok = 0;
        end
        check("seq warp held", ok, 1);
        warp_ack = 1'b1;
        @(negedge CLK);
        warp_ack = 1'b0;
        check("seq warp_valid after ack", int'(warp_valid), 0);
        check("seq busy in cooldown", int'(busy), 1);
        n_ts = 0;
        // First cooldown tick via a 10-cycle strobe: must count once.
        strobe(10);
        strobe(2);
        strobe(2);
        check("seq busy after 3 ticks", int'(busy), 1);
        strobe(2);
        check("seq busy after 4 ticks", int'(busy), 0);
        check("seq no pulse ticks 1-4", n_ts, 0);
        strobe(2);
        check("seq tick 5 pulse", n_ts, 1);
        do_reset();

        // Stray ack in ARMED.
        warp_ack = 1'b1;
        repeat (2) @(negedge CLK);
        warp_ack = 1'b0;
        @(negedge CLK);
        check("stray ack busy", int'(busy), 0);
        check("stray ack warp_valid", int'(warp_valid), 0);

        // Async reset during WARP.
        background_number = 11'h004;
        player_y = 10'd0;
        player_vy = 10'h3FF;
        n_ts = 0;
        strobe(2);
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin
            if (warp_valid) ok = 1;
            else @(negedge CLK);
        end
        check("rst reached warp", ok, 1);
        wy_before = warp_y;
        check("rst warp_y before", int'(wy_before), 456);
        #2 reset = 1'b1;
        #1;
        check("rst async warp_valid", int'(warp_valid), 0);
        check("rst async busy", int'(busy), 0);
        check("rst async warp_y", int'(warp_y), 0);
        @(negedge CLK);
        reset = 1'b0;
        ok = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (ts_collide || bs_collide || warp_valid || busy || warp_y != 10'd0) ok = 0;
        end
        check("rst quiet after release", ok, 1);
        n_ts = 0;
        strobe(2);
        check("rst first tick evaluated", n_ts, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
